// File: rtl/multdiv_sequencer_pkg.sv
// Shared constants for the mult/div sequencer: FSM encoding, exception
// writeback values and the ALU opcodes that select the multdiv operation.
package multdiv_sequencer_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_BUSY = 2'd1;
   localparam state_t ST_HOLD = 2'd2;

   localparam int RSTATUS_REG = 30;
   localparam int EXC_MULT    = 4;
   localparam int EXC_DIV     = 5;

   localparam logic [4:0] ALU_MULT = 5'b00110;
   localparam logic [4:0] ALU_DIV  = 5'b00111;

   function automatic logic [4:0] md_opcode(input logic is_div);
      return is_div ? ALU_DIV : ALU_MULT;
   endfunction

endpackage

// File: rtl/multdiv_sequencer_md_wb_arbiter.sv
// Regfile write-port mux: pipeline writeback first, then a fresh multdiv
// result, then the one-entry hold buffer filled when the pipe owned the port.
module md_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clock,
   input  logic              wb_pipe_we,
   input  logic [REG_W-1:0]  wb_pipe_rd,
   input  logic [DATA_W-1:0] wb_pipe_data,
   input  logic              res_valid,
   input  logic [REG_W-1:0]  res_rd,
   input  logic [DATA_W-1:0] res_data,
   input  logic              hold_valid,
   output logic              ctrl_writeEnable,
   output logic [REG_W-1:0]  ctrl_writeReg,
   output logic [DATA_W-1:0] data_writeReg
);

   logic [REG_W-1:0]  hold_rd;
   logic [DATA_W-1:0] hold_data;

   // Buffer contents are only meaningful while the FSM sits in HOLD.
   always_ff @(posedge clock) begin
      if (res_valid && wb_pipe_we) begin
         hold_rd   <= res_rd;
         hold_data <= res_data;
      end
   end

   always_comb begin
      ctrl_writeEnable = wb_pipe_we;
      ctrl_writeReg    = wb_pipe_rd;
      data_writeReg    = wb_pipe_data;
      if (!wb_pipe_we) begin
         if (res_valid) begin
            ctrl_writeEnable = 1'b1;
            ctrl_writeReg    = res_rd;
            data_writeReg    = res_data;
         end else if (hold_valid) begin
            ctrl_writeEnable = 1'b1;
            ctrl_writeReg    = hold_rd;
            data_writeReg    = hold_data;
         end
      end
   end

endmodule

// File: rtl/multdiv_sequencer.sv
// Mult/div issue sequencer with hazard tracking and regfile write arbitration.
// Define MD_TIMEOUT_EN to turn a missing md_ready into a status exception.
module multdiv_sequencer
   import multdiv_sequencer_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_W      = 5,
   parameter int MAX_CYCLES = 40,
   parameter int CNT_W      = 6
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              issue_valid,
   input  logic              issue_is_div,
   input  logic [REG_W-1:0]  issue_rd,
   output logic              issue_stall,
   output logic              md_ctrl_mult,
   output logic              md_ctrl_div,
   input  logic              md_ready,
   input  logic [DATA_W-1:0] md_result,
   input  logic              md_exception,
   input  logic [REG_W-1:0]  dec_rs,
   input  logic [REG_W-1:0]  dec_rt,
   input  logic [REG_W-1:0]  dec_rd,
   input  logic              dec_valid,
   output logic              hazard_stall,
   input  logic              wb_pipe_we,
   input  logic [REG_W-1:0]  wb_pipe_rd,
   input  logic [DATA_W-1:0] wb_pipe_data,
   output logic              ctrl_writeEnable,
   output logic [REG_W-1:0]  ctrl_writeReg,
   output logic [DATA_W-1:0] data_writeReg,
   output logic [CNT_W-1:0]  busy_cycles
);

`ifdef MD_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif
   // Fires in the MAX_CYCLES-th BUSY cycle, i.e. when the counter shows one less.
   localparam logic [CNT_W-1:0] TIMEOUT_AT = CNT_W'(MAX_CYCLES - 1);

   state_t            state, state_nxt;
   logic [REG_W-1:0]  pend_rd;
   logic              pend_div;
   logic [4:0]        op;
   logic              accept, timeout, done, exc;
   logic              res_valid, hold_load;
   logic [REG_W-1:0]  res_rd;
   logic [DATA_W-1:0] res_data;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   function automatic logic reg_match(input logic [REG_W-1:0] r,
                                      input logic [REG_W-1:0] rs,
                                      input logic [REG_W-1:0] rt,
                                      input logic [REG_W-1:0] rd);
      return (rs == r) || (rt == r) || (rd == r);
   endfunction

   assign op           = md_opcode(issue_is_div);
   assign accept       = (state == ST_IDLE) && issue_valid;
   assign md_ctrl_mult = accept && (op == ALU_MULT);
   assign md_ctrl_div  = accept && (op == ALU_DIV);
   assign issue_stall  = (state != ST_IDLE) && issue_valid;

   assign timeout = TIMEOUT_EN && (state == ST_BUSY) && (busy_cycles >= TIMEOUT_AT);
   assign done    = (state == ST_BUSY) && (md_ready || timeout);
   assign exc     = md_exception || timeout;
   assign res_rd  = exc ? REG_W'(RSTATUS_REG) : pend_rd;
   assign res_data = exc ? (pend_div ? DATA_W'(EXC_DIV) : DATA_W'(EXC_MULT)) : md_result;

   // A clean result aimed at r0 is dropped instead of occupying the port.
   assign res_valid = done && (exc || (pend_rd != '0));
   assign hold_load = res_valid && wb_pipe_we;

   assign hazard_stall = dec_valid &&
      (((state != ST_IDLE) && (pend_rd != '0) && reg_match(pend_rd, dec_rs, dec_rt, dec_rd)) ||
       (issue_stall && reg_match(issue_rd, dec_rs, dec_rt, dec_rd)));

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) state_nxt = ST_BUSY;
         ST_BUSY: if (done) state_nxt = hold_load ? ST_HOLD : ST_IDLE;
         ST_HOLD: if (!wb_pipe_we) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         pend_rd     <= '0;
         pend_div    <= 1'b0;
         busy_cycles <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            pend_rd     <= issue_rd;
            pend_div    <= issue_is_div;
            busy_cycles <= '0;
         end else begin
            // Track the exception destination while the result waits in HOLD.
            if (hold_load) pend_rd <= res_rd;
            if (state == ST_BUSY) busy_cycles <= sat_inc(busy_cycles);
         end
      end
   end

   md_wb_arbiter #(
      .DATA_W (DATA_W),
      .REG_W  (REG_W)
   ) u_arb (
      .clock            (clock),
      .wb_pipe_we       (wb_pipe_we),
      .wb_pipe_rd       (wb_pipe_rd),
      .wb_pipe_data     (wb_pipe_data),
      .res_valid        (res_valid),
      .res_rd           (res_rd),
      .res_data         (res_data),
      .hold_valid       (state == ST_HOLD),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .data_writeReg    (data_writeReg)
   );

endmodule
